// File: rtl/seq_pkg.sv
// Shared definitions for the 11011 pattern generator and its companion detectors.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  localparam logic [4:0]  PATTERN_11011 = 5'b11011;
  localparam int unsigned OVL_LEN_11011 = 2;

endpackage

// File: rtl/seq11011_gen.sv
// Framed serial generator for the 11011 pattern, MSB first, with repeat count,
// inter-frame gap and overlap mode. All outputs are registered.
module seq11011_gen
  import seq_pkg::*;
#(
  parameter logic [4:0]  PATTERN = PATTERN_11011,
  parameter int unsigned OVL_LEN = OVL_LEN_11011,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             overlap,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             frame_done,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [2:0] FIRST_IDX   = 3'd4;
  localparam logic [2:0] RESTART_IDX = 3'(4 - OVL_LEN);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ovl_q, ovl_d;

  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             fdone_q, fdone_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  // idx_q names the pattern bit on dout this cycle; next-cycle outputs are
  // derived from the next position so every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    ovl_d   = ovl_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && (repeat_cnt != '0)) begin
          rep_d   = repeat_cnt;
          gap_d   = gap;
          ovl_d   = overlap;
          fcnt_d  = '0;
          idx_d   = FIRST_IDX;
          state_d = SEND;
        end
      end
      SEND: begin
        if (idx_q != 3'd0) begin
          idx_d = idx_q - 3'd1;
        end else if (fcnt_q == rep_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (ovl_q) begin
          idx_d = RESTART_IDX;
        end else if (gap_q != '0) begin
          state_d = GAP;
          gcnt_d  = gap_q;
        end else begin
          idx_d = FIRST_IDX;
        end
      end
      GAP: begin
        if (gcnt_q == GAP_W'(1)) begin
          state_d = SEND;
          idx_d   = FIRST_IDX;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == SEND);
    dout_d  = valid_d & PATTERN[idx_d];
    fdone_d = valid_d && (idx_d == 3'd0);
    busy_d  = (state_d != IDLE);
    // fcnt_q already counts the frame whose last bit is on dout
    if (fdone_d) begin
      fcnt_d = fcnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gcnt_q  <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      ovl_q   <= 1'b0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      ovl_q   <= ovl_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign dout       = dout_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign done       = done_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_seq11011_gen.sv
// Scoreboard bench for seq11011_gen: stimulus expands each accepted burst into a
// per-cycle expected stream; a negedge monitor compares every cycle.
module tb_seq11011_gen;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             overlap;
  logic             dout, valid, busy, frame_done, done;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  seq11011_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .repeat_cnt(repeat_cnt), .gap(gap),
    .overlap(overlap), .dout(dout), .valid(valid), .busy(busy),
    .frame_done(frame_done), .done(done), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int unsigned cyc;
    logic        dout, valid, busy, fd, done;
    logic [7:0]  fc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int unsigned cyc = 0;
  int unsigned next_free = 0;
  int          checks = 0, errors = 0;
  logic [7:0]  idle_fc = 8'd0;
  logic [4:0]  det_h = 5'd0;
  int          det_hits = 0;
  int          base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  // Monitor: an expected entry for this cycle is popped; otherwise the DUT must idle.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        me = q.pop_front();
        idle_fc = me.fc;
      end else begin
        me = '{cyc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle_fc};
      end
      check("dout",       32'(dout),       32'(me.dout));
      check("valid",      32'(valid),      32'(me.valid));
      check("busy",       32'(busy),       32'(me.busy));
      check("frame_done", 32'(frame_done), 32'(me.fd));
      check("done",       32'(done),       32'(me.done));
      check("frame_cnt",  32'(frame_cnt),  32'(me.fc));
      if (valid === 1'b1) begin
        det_h = {det_h[3:0], dout};
        if (det_h == 5'b11011) det_hits++;
      end else begin
        det_h = 5'd0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a burst is the text "11011" per frame; overlapped frames reuse
  // the trailing "11", so only "011" is new.
  task automatic model_burst(int unsigned n, int unsigned g, bit o);
    int unsigned t = cyc + 1;
    logic [7:0]  fc = 8'd0;
    string       bits;
    for (int f = 0; f < int'(n); f++) begin
      bits = (f == 0 || !o) ? "11011" : "011";
      for (int j = 0; j < bits.len(); j++) begin
        bit last = (j == bits.len() - 1);
        if (last) fc++;
        q.push_back('{t, (bits[j] == "1"), 1'b1, 1'b1, last, 1'b0, fc});
        t++;
      end
      if (f != int'(n) - 1 && !o) begin
        for (int k = 0; k < int'(g); k++) begin
          q.push_back('{t, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fc});
          t++;
        end
      end
    end
    q.push_back('{t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fc});
    next_free = t;
  endtask

  task automatic drive(bit s, logic [7:0] r, logic [3:0] g, bit o);
    start = s; repeat_cnt = r; gap = g; overlap = o;
    if (s && !rst && cyc >= next_free && r != 8'd0) model_burst(r, g, o);
    tick();
    start = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 8'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1; start = 1'b1;
      while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
      q.push_back('{cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
      tick();
    end
    rst = 1'b0; start = 1'b0;
    next_free = cyc;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; repeat_cnt = '0; gap = '0; overlap = 1'b0;
    do_reset(3);

    while (cyc < 10) drive(1'b0, 8'd1, 4'd0, 1'b0);
    drive(1'b1, 8'd1, 4'd0, 1'b0);
    idle(10);

    drive(1'b1, 8'd2, 4'd3, 1'b0);
    idle(20);

    base = det_hits;
    drive(1'b1, 8'd3, 4'd5, 1'b1);
    idle(15);
    check("ovl_hits", 32'(det_hits - base), 32'd3);

    drive(1'b1, 8'd2, 4'd2, 1'b0);
    repeat (8) drive(1'b1, 8'($urandom_range(1, 9)), 4'($urandom), 1'($urandom));
    while (cyc < next_free) drive(1'b0, 8'd0, 4'd0, 1'b0);
    drive(1'b1, 8'd1, 4'd0, 1'b0);
    idle(8);

    repeat (4) drive(1'b1, 8'd0, 4'($urandom), 1'($urandom));
    idle(2);

    drive(1'b1, 8'd2, 4'd0, 1'b0);
    idle(2);
    do_reset(1);
    drive(1'b1, 8'd1, 4'd0, 1'b0);
    idle(8);

    repeat (3000) begin
      if ($urandom_range(0, 99) == 0)
        do_reset(int'($urandom_range(1, 3)));
      else
        drive($urandom_range(0, 3) == 0, 8'($urandom_range(0, 4)),
              4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle(60);

    check("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
